// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS-15 pattern source and its byte-step LFSR:
// state encoding, LFSR taps, default seed and datapath widths.
package prbs_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;
  localparam int LFSR_W = 15;
  localparam int CNT_W  = 16;

  // Feedback taps of x^15 + x^14 + 1
  localparam int TAP_HI = 14;
  localparam int TAP_LO = 13;

  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 15'h7FFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PATTERN = 2'd1,
    PRBS    = 2'd2
  } state_t;

  // Byte idx of the preamble word, idx 0 being the most significant byte.
  function automatic logic [BYTE_W-1:0] pattern_byte(input logic [WORD_W-1:0] word,
                                                     input logic [1:0]        idx);
    logic [BYTE_W-1:0] b;
    case (idx)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/prbs15_byte_step.sv
// Combinational PRBS-15 advance by eight steps; the first generated bit lands
// in byte_out[7]. Shared with the detector-side checker.
module prbs15_byte_step
  import prbs_pkg::*;
(
  input  logic [LFSR_W-1:0] lfsr_in,
  output logic [LFSR_W-1:0] lfsr_out,
  output logic [BYTE_W-1:0] byte_out
);

  logic [LFSR_W-1:0] s;
  logic              nb;

  always_comb begin
    // NOTE: blocking assignments here are intentional: each unrolled step
    // must see the value produced by the step before it.
    s        = lfsr_in;
    nb       = 1'b0;
    byte_out = '0;
    for (int i = 0; i < BYTE_W; i++) begin
      nb                   = s[TAP_HI] ^ s[TAP_LO];
      byte_out[BYTE_W-1-i] = nb;
      s                    = {s[LFSR_W-2:0], nb};
    end
    lfsr_out = s;
  end

endmodule

// File: rtl/prbs15_pattern_source.sv
// Byte source: n repetitions of a 32-bit preamble word, then a PRBS-15 byte
// stream that is either length-limited (done pulse) or runs until stop.
module prbs15_pattern_source
  import prbs_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED       = DEFAULT_SEED,
  parameter int unsigned       PRBS_BYTES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [WORD_W-1:0] pattern,
  input  logic [3:0]        n,
  output logic [BYTE_W-1:0] data_out,
  output logic              data_valid,
  output logic              preamble,
  output logic              busy,
  output logic              done
);

  localparam logic [CNT_W-1:0] PRBS_LIMIT = CNT_W'(PRBS_BYTES);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_t            state, state_next;
  logic [LFSR_W-1:0] lfsr, lfsr_d, step_in, step_lfsr;
  logic [BYTE_W-1:0] step_byte, data_d;
  logic [WORD_W-1:0] pat_q, pat_d;
  logic [3:0]        n_q, n_d, rep, rep_d;
  logic [1:0]        idx, idx_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              valid_d, pre_d, busy_d, done_d;
  logic              last_pattern_byte, prbs_finished;

  // A fresh start steps from SEED directly so the first PRBS byte needs no bubble.
  assign step_in = (state == IDLE) ? SEED : lfsr;

  prbs15_byte_step u_step (
    .lfsr_in  (step_in),
    .lfsr_out (step_lfsr),
    .byte_out (step_byte)
  );

  assign last_pattern_byte = (idx == 2'd3) && (rep == n_q - 4'd1);
  assign prbs_finished     = (PRBS_LIMIT != '0) && (cnt == PRBS_LIMIT);

  // State register plus the registered datapath and outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      lfsr       <= SEED;
      pat_q      <= '0;
      n_q        <= '0;
      idx        <= '0;
      rep        <= '0;
      cnt        <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      preamble   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      state      <= state_next;
      lfsr       <= lfsr_d;
      pat_q      <= pat_d;
      n_q        <= n_d;
      idx        <= idx_d;
      rep        <= rep_d;
      cnt        <= cnt_d;
      data_out   <= data_d;
      data_valid <= valid_d;
      preamble   <= pre_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

  // Next state; stop overrides everything, including a simultaneous start.
  always_comb begin
    state_next = state;
    if (stop) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (start) state_next = (n == 4'd0) ? PRBS : PATTERN;
        PATTERN: if (last_pattern_byte) state_next = PRBS;
        PRBS:    if (prbs_finished) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Values the registers take at the next edge, keyed on the state being entered.
  always_comb begin
    // NOTE: every signal is given a default first so no path infers a latch.
    lfsr_d  = lfsr;
    pat_d   = pat_q;
    n_d     = n_q;
    idx_d   = idx;
    rep_d   = rep;
    cnt_d   = cnt;
    data_d  = data_out;
    valid_d = 1'b0;
    pre_d   = 1'b0;
    done_d  = 1'b0;
    busy_d  = (state_next != IDLE);

    if (state == IDLE && state_next != IDLE) begin
      pat_d  = pattern;
      n_d    = n;
      idx_d  = '0;
      rep_d  = '0;
      cnt_d  = '0;
      lfsr_d = SEED;
    end

    unique case (state_next)
      IDLE: done_d = (state == PRBS) && !stop;
      PATTERN: begin
        valid_d = 1'b1;
        pre_d   = 1'b1;
        if (state == PATTERN) begin
          idx_d = idx + 2'd1;
          if (idx == 2'd3) rep_d = rep + 4'd1;
        end
        data_d = pattern_byte(pat_d, idx_d);
      end
      PRBS: begin
        valid_d = 1'b1;
        data_d  = step_byte;
        lfsr_d  = step_lfsr;
        if (state != PRBS)      cnt_d = CNT_W'(1);
        else if (cnt != CNT_MAX) cnt_d = cnt + CNT_W'(1);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_prbs15_pattern_source.sv
// Bench for prbs15_pattern_source: a length-limited and a continuous instance
// share stimulus and are checked every cycle against a position-indexed stream model.
module tb_prbs15_pattern_source;

  localparam int TAB_N = 1024;
  localparam int NBITS = 15 + 8 * TAB_N;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [31:0] pattern = '0;
  logic [3:0]  n = '0;

  logic [7:0] d0, d1;
  logic       v0, v1, p0, p1, b0, b1, dn0, dn1;

  int checks = 0;
  int failures = 0;

  // Expected stream: PRBS bytes from the bit recurrence g[j] = g[j-15] ^ g[j-14].
  logic       prbs_bits [NBITS];
  logic [7:0] prbs_tab  [TAB_N];

  // Per-instance model: instance 0 stops after 16 PRBS bytes, instance 1 never does.
  int          lim   [2] = '{16, 0};
  bit          m_act [2];
  int          m_pos [2];
  logic [31:0] m_pat [2];
  int          m_n   [2];
  logic [7:0]  m_data[2];
  bit          m_done[2];

  logic [7:0] lit_t1 [10] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h02};
  logic [7:0] lit_t4 [6]  = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'h02};

  prbs15_pattern_source #(.SEED(15'h7FFF), .PRBS_BYTES(16)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pattern(pattern), .n(n),
    .data_out(d0), .data_valid(v0), .preamble(p0), .busy(b0), .done(dn0)
  );

  prbs15_pattern_source #(.SEED(15'h7FFF), .PRBS_BYTES(0)) dut_c (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pattern(pattern), .n(n),
    .data_out(d1), .data_valid(v1), .preamble(p1), .busy(b1), .done(dn1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_byte(input int i);
    logic [31:0] w;
    if (m_pos[i] < 4 * m_n[i]) begin
      w = m_pat[i] >> (8 * (3 - (m_pos[i] % 4)));
      return w[7:0];
    end
    return prbs_tab[m_pos[i] - 4 * m_n[i]];
  endfunction

  // Advance the model by one clock using the inputs as they are at the edge.
  task automatic model_step(input int i);
    m_done[i] = 1'b0;
    if (!rst) begin
      m_act[i]  = 1'b0;
      m_pos[i]  = 0;
      m_data[i] = 8'h00;
    end else if (stop) begin
      m_act[i] = 1'b0;
    end else if (!m_act[i]) begin
      if (start) begin
        m_act[i] = 1'b1;
        m_pos[i] = 0;
        m_pat[i] = pattern;
        m_n[i]   = int'(n);
      end
    end else begin
      m_pos[i]++;
      if (lim[i] != 0 && m_pos[i] >= 4 * m_n[i] + lim[i]) begin
        m_act[i]  = 1'b0;
        m_done[i] = 1'b1;
      end
    end
    if (m_act[i]) m_data[i] = model_byte(i);
  endtask

  task automatic cmp(input int i, input logic [7:0] d, input logic v, input logic p,
                     input logic b, input logic dn);
    check($sformatf("valid%0d", i), 32'(v), 32'(m_act[i]));
    check($sformatf("busy%0d", i), 32'(b), 32'(m_act[i]));
    check($sformatf("preamble%0d", i), 32'(p), 32'(m_act[i] && (m_pos[i] < 4 * m_n[i])));
    check($sformatf("done%0d", i), 32'(dn), 32'(m_done[i]));
    check($sformatf("data%0d", i), 32'(d), 32'(m_data[i]));
  endtask

  // One clock: update the model at the edge, compare just after it.
  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    cmp(0, d0, v0, p0, b0, dn0);
    cmp(1, d1, v1, p1, b1, dn1);
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic pulse_start(input logic [31:0] pat, input logic [3:0] reps);
    pattern = pat;
    n       = reps;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  initial begin
    for (int j = 0; j < 15; j++) prbs_bits[j] = 1'b1;
    for (int j = 15; j < NBITS; j++) prbs_bits[j] = prbs_bits[j-15] ^ prbs_bits[j-14];
    for (int m = 0; m < TAB_N; m++) begin
      prbs_tab[m] = '0;
      for (int k = 0; k < 8; k++) prbs_tab[m][7-k] = prbs_bits[15 + 8*m + k];
    end
    check("tab0", 32'(prbs_tab[0]), 32'h00);
    check("tab1", 32'(prbs_tab[1]), 32'h02);
    check("tab2", 32'(prbs_tab[2]), 32'h00);
    check("tab3", 32'(prbs_tab[3]), 32'h0C);

    #2 rst = 1'b0;
    #1;
    check("rst_data", 32'(d0), 32'h00);
    check("rst_busy", 32'(b0), 32'h0);
    ticks(2);
    rst = 1'b1;
    ticks(2);

    // Preamble twice, then seamless PRBS.
    pulse_start(32'hDEADBEEF, 4'd2);
    for (int k = 0; k < 10; k++) begin
      check("t1_data", 32'(d0), 32'(lit_t1[k]));
      check("t1_pre", 32'(p0), 32'(k < 8));
      check("t1_valid", 32'(v0), 32'h1);
      tick();
    end
    pulse_stop();
    tick();

    // No preamble: PRBS from the very first byte.
    pulse_start(32'h01020304, 4'd0);
    check("t2_b0", 32'(d0), 32'h00);
    check("t2_pre", 32'(p0), 32'h0);
    tick();
    check("t2_b1", 32'(d0), 32'h02);
    ticks(18);
    pulse_stop();
    tick();

    // Length-limited run: 4 + 16 bytes, then a single done pulse.
    pulse_start(32'hA5A5_5A5A, 4'd1);
    for (int k = 0; k < 20; k++) begin
      check("t3_valid", 32'(v0), 32'h1);
      check("t3_nodone", 32'(dn0), 32'h0);
      tick();
    end
    check("t3_done", 32'(dn0), 32'h1);
    check("t3_busy", 32'(b0), 32'h0);
    check("t3_gap", 32'(v0), 32'h0);
    tick();
    check("t3_done_clr", 32'(dn0), 32'h0);
    pulse_stop();

    // Stop during the third pattern byte, then restart fresh.
    pulse_start(32'hAABBCCDD, 4'd3);
    ticks(2);
    check("t4_third", 32'(d0), 32'hCC);
    pulse_stop();
    check("t4_valid", 32'(v0), 32'h0);
    check("t4_busy", 32'(b0), 32'h0);
    tick();
    pulse_start(32'h12345678, 4'd1);
    for (int k = 0; k < 6; k++) begin
      check("t4_data", 32'(d0), 32'(lit_t4[k]));
      tick();
    end
    pulse_stop();

    // Start mid-PRBS is ignored; start with stop in IDLE stays idle.
    pulse_start(32'h0, 4'd0);
    ticks(3);
    pulse_start(32'hFFFF_FFFF, 4'd5);
    check("t5_cont", 32'(d0), 32'(prbs_tab[4]));
    ticks(2);
    pulse_stop();
    stop = 1'b1;
    pulse_start(32'h11223344, 4'd2);
    stop = 1'b0;
    check("t5_idle", 32'(b0), 32'h0);
    tick();

    // Asynchronous reset between edges in the middle of the preamble.
    pulse_start(32'hCAFEF00D, 4'd4);
    ticks(2);
    #2 rst = 1'b0;
    #1;
    check("t6_valid0", 32'(v0), 32'h0);
    check("t6_busy0", 32'(b0), 32'h0);
    check("t6_valid1", 32'(v1), 32'h0);
    check("t6_busy1", 32'(b1), 32'h0);
    check("t6_data0", 32'(d0), 32'h00);
    ticks(2);
    rst = 1'b1;
    ticks(3);
    pulse_start(32'h12345678, 4'd1);
    check("t6_first", 32'(d0), 32'h12);
    ticks(4);
    check("t6_prbs", 32'(d0), 32'h00);
    pulse_stop();

    // Randomized traffic including occasional resets.
    for (int c = 0; c < 2500; c++) begin
      start   = ($urandom_range(0, 11) == 0);
      stop    = ($urandom_range(0, 49) == 0) || (m_pos[1] > 800);
      pattern = $urandom;
      n       = 4'($urandom_range(0, 15));
      rst     = ($urandom_range(0, 399) != 0);
      tick();
    end
    start = 1'b0;
    stop  = 1'b0;
    rst   = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
